// File: rtl/ega_pkg.sv
// Shared definitions for the EGA graphics sequencer: register indices,
// write-mode and ALU encodings, FSM state codes and a byte rotate helper.
package ega_pkg;

    localparam logic [3:0] GR_SET_RESET    = 4'd0;
    localparam logic [3:0] GR_EN_SET_RESET = 4'd1;
    localparam logic [3:0] GR_COLOR_CMP    = 4'd2;
    localparam logic [3:0] GR_ROTATE_ALU   = 4'd3;
    localparam logic [3:0] GR_READ_PLANE   = 4'd4;
    localparam logic [3:0] GR_MODE         = 4'd5;
    localparam logic [3:0] GR_DONT_CARE    = 4'd7;
    localparam logic [3:0] GR_BIT_MASK     = 4'd8;
    localparam logic [3:0] SQ_MAP_MASK     = 4'd2;

    typedef enum logic [1:0] {
        WMODE_0 = 2'd0,
        WMODE_1 = 2'd1,
        WMODE_2 = 2'd2,
        WMODE_3 = 2'd3
    } wmode_e;

    typedef enum logic [1:0] {
        ALU_COPY = 2'd0,
        ALU_AND  = 2'd1,
        ALU_OR   = 2'd2,
        ALU_XOR  = 2'd3
    } alu_fn_e;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WR_ISSUE = 2'd1;
    localparam logic [1:0] ST_RD_ISSUE = 2'd2;
    localparam logic [1:0] ST_RD_DATA  = 2'd3;

    function automatic logic [7:0] ror8(input logic [7:0] v, input logic [2:0] n);
        logic [15:0] t;
        t = {v, v} >> n;
        return t[7:0];
    endfunction

endpackage

// File: rtl/ega_gfx_sequencer_if.sv
// CPU-side memory/config port and shared VRAM port of the graphics sequencer.
interface ega_gfx_sequencer_if #(parameter int ADDR_W = 14);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wr_data;
    logic [7:0]        rd_data;
    logic              ack;
    logic              cfg_wr;
    logic              cfg_seq;
    logic [3:0]        cfg_idx;
    logic [7:0]        cfg_data;
    logic              vram_busy;
    logic [ADDR_W-1:0] vram_addr;
    logic              vram_rd;
    logic [31:0]       vram_rd_data;
    logic [3:0]        vram_we;
    logic [31:0]       vram_wr_data;

    modport slave (
        input  req, we, addr, wr_data, cfg_wr, cfg_seq, cfg_idx, cfg_data,
        input  vram_busy, vram_rd_data,
        output rd_data, ack, vram_addr, vram_rd, vram_we, vram_wr_data
    );

    modport master (
        output req, we, addr, wr_data, cfg_wr, cfg_seq, cfg_idx, cfg_data,
        output vram_busy, vram_rd_data,
        input  rd_data, ack, vram_addr, vram_rd, vram_we, vram_wr_data
    );
endinterface

// File: rtl/ega_gfx_alu.sv
// One plane of the write datapath: rotate / set-reset / mode-2 expand,
// ALU against the read latch, then bit-mask merge. Mode 1 passes the latch.
module ega_gfx_alu
    import ega_pkg::*;
(
    input  logic [7:0] cpu_data,
    input  logic       data_bit,
    input  logic [7:0] latch,
    input  logic [2:0] rotate,
    input  alu_fn_e    alu_fn,
    input  wmode_e     write_mode,
    input  logic       set_reset,
    input  logic       en_set_reset,
    input  logic [7:0] bit_mask,
    output logic [7:0] result
);
    logic [7:0] src;
    logic [7:0] alu_out;
    logic [7:0] merged;

    always_comb begin
        src = ror8(cpu_data, rotate);
        if (en_set_reset) begin
            src = {8{set_reset}};
        end
        // Mode 2 ignores rotate and set/reset: the data bit selects the colour
        if (write_mode == WMODE_2) begin
            src = {8{data_bit}};
        end

        alu_out = src;
        case (alu_fn)
            ALU_AND: alu_out = src & latch;
            ALU_OR:  alu_out = src | latch;
            ALU_XOR: alu_out = src ^ latch;
            default: alu_out = src;
        endcase

        merged = (bit_mask & alu_out) | (~bit_mask & latch);
        result = (write_mode == WMODE_1) ? latch : merged;
    end
endmodule

// File: rtl/ega_gfx_sequencer.sv
// EGA graphics-controller sequencer: register file, 32-bit read latches and
// the FSM that turns CPU cycles into VRAM accesses, yielding to the CRTC.
module ega_gfx_sequencer
    import ega_pkg::*;
#(
    parameter int         ADDR_W       = 14,
    parameter logic [3:0] RST_MAP_MASK = 4'hF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ega_gfx_sequencer_if.slave   bus
);
    logic [3:0]        set_reset_reg;
    logic [3:0]        en_sr_reg;
    logic [3:0]        color_cmp_reg;
    logic [2:0]        rotate_reg;
    alu_fn_e           alu_fn_reg;
    logic [1:0]        read_plane_reg;
    wmode_e            write_mode_reg;
    logic              read_mode_reg;
    logic [3:0]        dont_care_reg;
    logic [7:0]        bit_mask_reg;
    logic [3:0]        map_mask_reg;

    logic [1:0]        state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [7:0]        data_reg;
    logic [31:0]       latch_reg;
    logic [7:0]        rd_data_reg;
    logic              ack_reg;

    logic [7:0]        rd_plane [4];
    logic [7:0]        cmp_match [4];
    logic [31:0]       wr_result;
    logic [7:0]        rd_result;
    logic              wr_issue;
    logic              rd_issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_reset_reg  <= '0;
            en_sr_reg      <= '0;
            color_cmp_reg  <= '0;
            rotate_reg     <= '0;
            alu_fn_reg     <= ALU_COPY;
            read_plane_reg <= '0;
            write_mode_reg <= WMODE_0;
            read_mode_reg  <= 1'b0;
            dont_care_reg  <= '0;
            bit_mask_reg   <= 8'hFF;
            map_mask_reg   <= RST_MAP_MASK;
        end else if (bus.cfg_wr) begin
            if (bus.cfg_seq) begin
                if (bus.cfg_idx == SQ_MAP_MASK) map_mask_reg <= bus.cfg_data[3:0];
            end else begin
                case (bus.cfg_idx)
                    GR_SET_RESET:    set_reset_reg <= bus.cfg_data[3:0];
                    GR_EN_SET_RESET: en_sr_reg     <= bus.cfg_data[3:0];
                    GR_COLOR_CMP:    color_cmp_reg <= bus.cfg_data[3:0];
                    GR_ROTATE_ALU: begin
                        rotate_reg <= bus.cfg_data[2:0];
                        alu_fn_reg <= alu_fn_e'(bus.cfg_data[4:3]);
                    end
                    GR_READ_PLANE:   read_plane_reg <= bus.cfg_data[1:0];
                    GR_MODE: begin
                        write_mode_reg <= wmode_e'(bus.cfg_data[1:0]);
                        read_mode_reg  <= bus.cfg_data[3];
                    end
                    GR_DONT_CARE:    dont_care_reg <= bus.cfg_data[3:0];
                    GR_BIT_MASK:     bit_mask_reg  <= bus.cfg_data;
                    default: ;
                endcase
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_plane
            assign rd_plane[gi]  = bus.vram_rd_data[8*gi +: 8];
            // Colour-compare match; planes marked don't-care match unconditionally
            assign cmp_match[gi] = ~(rd_plane[gi] ^ {8{color_cmp_reg[gi]}})
                                 | {8{~dont_care_reg[gi]}};

            ega_gfx_alu u_alu (
                .cpu_data     (data_reg),
                .data_bit     (data_reg[gi]),
                .latch        (latch_reg[8*gi +: 8]),
                .rotate       (rotate_reg),
                .alu_fn       (alu_fn_reg),
                .write_mode   (write_mode_reg),
                .set_reset    (set_reset_reg[gi]),
                .en_set_reset (en_sr_reg[gi]),
                .bit_mask     (bit_mask_reg),
                .result       (wr_result[8*gi +: 8])
            );
        end
    endgenerate

    assign rd_result = read_mode_reg
                     ? (cmp_match[0] & cmp_match[1] & cmp_match[2] & cmp_match[3])
                     : rd_plane[read_plane_reg];

    assign wr_issue = (state_reg == ST_WR_ISSUE) && !bus.vram_busy;
    assign rd_issue = (state_reg == ST_RD_ISSUE) && !bus.vram_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= '0;
            data_reg    <= '0;
            latch_reg   <= '0;
            rd_data_reg <= '0;
            ack_reg     <= 1'b0;
        end else begin
            ack_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.req) begin
                        addr_reg  <= bus.addr;
                        data_reg  <= bus.wr_data;
                        state_reg <= bus.we ? ST_WR_ISSUE : ST_RD_ISSUE;
                    end
                end
                ST_WR_ISSUE: begin
                    if (wr_issue) begin
                        ack_reg   <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                ST_RD_ISSUE: begin
                    if (rd_issue) state_reg <= ST_RD_DATA;
                end
                default: begin
                    latch_reg   <= bus.vram_rd_data;
                    rd_data_reg <= rd_result;
                    ack_reg     <= 1'b1;
                    state_reg   <= ST_IDLE;
                end
            endcase
        end
    end

    // VRAM strobes are combinational so they can never overlap a busy cycle
    assign bus.vram_addr    = addr_reg;
    assign bus.vram_rd      = rd_issue;
    assign bus.vram_we      = wr_issue ? map_mask_reg : 4'h0;
    assign bus.vram_wr_data = wr_issue ? wr_result : 32'h0;
    assign bus.rd_data      = rd_data_reg;
    assign bus.ack          = ack_reg;
endmodule
